// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the held instruction: JALR > JAL/taken branch > sequential.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            is_branch_i,
    input  logic            branchtrue_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    logic [XLEN-1:0] jalr_sum;

    always_comb begin
        jalr_sum = rs1_i + imm_i;
        if (is_jalr_i) begin
            target_o = jalr_sum & ~XLEN'(1);
        end else if (is_jal_i || (is_branch_i && branchtrue_i)) begin
            target_o = pc_i + imm_i;
        end else begin
            target_o = pc_i + PC_INC;
        end
        misaligned_o = |target_o[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction fetch over a req/valid handshake.
// FETCH_MISALIGN_TRAP_EN: trap misaligned targets into a sticky HALT instead of aligning them.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            branchtrue,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            instr_ack,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] instr_out,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_exc
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            req_q, valid_q;
    logic [XLEN-1:0] target;
    logic            misaligned;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            exc_q, exc_d;
`endif

    next_pc_calc u_next_pc (
        .pc_i         (pc_q),
        .imm_i        (imm),
        .rs1_i        (rs1),
        .is_branch_i  (is_branch),
        .branchtrue_i (branchtrue),
        .is_jal_i     (is_jal),
        .is_jalr_i    (is_jalr),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    // req/valid flops follow the next state so they mirror the registered state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= (state_d == FETCH);
            valid_q <= (state_d == HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
            exc_q   <= exc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        exc_d   = exc_q;
`endif
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: state_d = WAIT;
            WAIT: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        exc_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
`else
                    pc_d    = misaligned ? {target[XLEN-1:2], 2'b00} : target;
                    state_d = FETCH;
`endif
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    assign imem_req    = req_q;
    assign instr_valid = valid_q;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_q + PC_INC;
    assign instr_out   = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_exc = exc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        branchtrue, is_branch, is_jal, is_jalr;
    logic [31:0] imm, rs1;
    logic        instr_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .branchtrue  (branchtrue),
        .is_branch   (is_branch),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .imm         (imm),
        .rs1         (rs1),
        .instr_ack   (instr_ack),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_exc(misalign_exc)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=boot 1=requesting 2=awaiting word 3=holding 4=halted
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_exc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_target();
        logic [31:0] t;
        if (is_jalr)                               t = (rs1 + imm) & 32'hFFFF_FFFE;
        else if (is_jal || (is_branch && branchtrue)) t = m_pc + imm;
        else                                       t = m_pc + 32'd4;
        return t;
    endfunction

    task automatic model_update();
        logic [31:0] t;
        if (rst) begin
            m_phase = 0; m_pc = RST_PC; m_instr = '0; m_exc = 1'b0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: m_phase = 2;
                2: if (imem_valid) begin m_instr = imem_rdata; m_phase = 3; end
                3: if (instr_ack) begin
                    t = ref_target();
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (t[1:0] != 2'b00) begin m_exc = 1'b1; m_phase = 4; end
                    else begin m_pc = t; m_phase = 1; end
`else
                    m_pc = {t[31:2], 2'b00}; m_phase = 1;
`endif
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("imem_req",    32'(imem_req),    32'(m_phase == 1));
        chk("instr_valid", 32'(instr_valid), 32'(m_phase == 3));
        chk("imem_addr",   imem_addr, m_pc);
        chk("pc_out",      pc_out,    m_pc);
        chk("pc_plus4",    pc_plus4,  m_pc + 32'd4);
        chk("instr_out",   instr_out, m_instr);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_exc", 32'(misalign_exc), 32'(m_exc));
`endif
    endtask

    // Inputs are set at a falling edge; model steps on the rising edge; outputs compared at the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_ctrl(input logic br, input logic bt, input logic jal, input logic jalr,
                            input logic [31:0] im, input logic [31:0] r1);
        is_branch = br; branchtrue = bt; is_jal = jal; is_jalr = jalr; imm = im; rs1 = r1;
    endtask

    task automatic rand_ctrl();
        set_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    // Run to the holding phase, then acknowledge with the given controls (lands in the request phase).
    task automatic do_instr(input logic br, input logic bt, input logic jal, input logic jalr,
                            input logic [31:0] im, input logic [31:0] r1);
        int n = 0;
        while (m_phase != 3 && n < 20) begin
            rand_ctrl();
            instr_ack = 1'b0; imem_valid = 1'b1; imem_rdata = $urandom;
            tick();
            n++;
        end
        if (n >= 20) begin
            errors++; checks++;
            $display("FAIL do_instr_timeout: got no hold phase within %0d cycles, required < 20", n);
        end
        set_ctrl(br, bt, jal, jalr, im, r1);
        instr_ack = 1'b1; imem_valid = 1'b0;
        tick();
        instr_ack = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, a);
        chk("jump_to_addr", imem_addr, a);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [31:0] addrs[$];
        int          vcount;
        int          halt_reqs;

        rst = 1'b1; instr_ack = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        m_phase = 0; m_pc = RST_PC; m_instr = '0; m_exc = 1'b0;
        @(negedge clk);
        tick(); tick();
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_pc",    pc_out, 32'h0000_0100);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);

        // Release: boot cycle has no request, then 1-cycle memory with immediate ack
        rst = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h1111_0000; instr_ack = 1'b1;
        #1 chk("boot_req", 32'(imem_req), 32'd0);
        vcount = 0;
        for (int i = 0; i < 9; i++) begin
            imem_rdata = 32'h1111_0000 + 32'(i);
            tick();
            if (imem_req) addrs.push_back(imem_addr);
            if (instr_valid) vcount++;
        end
        chk("first_req_cycle", 32'(addrs.size()), 32'd3);
        if (addrs.size() == 3) begin
            chk("seq_addr0", addrs[0], 32'h0000_0100);
            chk("seq_addr1", addrs[1], 32'h0000_0104);
            chk("seq_addr2", addrs[2], 32'h0000_0108);
        end
        chk("valid_pulses", 32'(vcount), 32'd3);
        instr_ack = 1'b0;

        // Branch taken / not taken at 0x20 with imm=-8
        jump_to(32'h0000_0020);
        do_instr(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
        chk("branch_taken", imem_addr, 32'h0000_0018);
        jump_to(32'h0000_0020);
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
        chk("branch_not_taken", imem_addr, 32'h0000_0024);

        // JALR target, and JALR priority over JAL
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_1001);
        chk("jalr_target", imem_addr, 32'h0000_1010);
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_1001);
        chk("jalr_over_jal", imem_addr, 32'h0000_1010);

        // Memory stall 4 cycles, then ack held off 3 cycles; stray ack/valid are ignored
        instr_ack = 1'b1; imem_valid = 1'b1; tick();
        imem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin rand_ctrl(); tick(); chk("stall_no_req", 32'(imem_req), 32'd0); end
        instr_ack = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
        for (int i = 0; i < 3; i++) begin
            rand_ctrl(); imem_rdata = $urandom; tick();
            chk("hold_instr_stable", instr_out, 32'hDEAD_BEEF);
            chk("hold_no_req", 32'(imem_req), 32'd0);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        instr_ack = 1'b1; imem_valid = 1'b0; tick();
        chk("after_stall_addr", imem_addr, 32'h0000_1014);

        // Reset during WAIT; late valid just after release is dropped
        instr_ack = 1'b0; imem_valid = 1'b0; tick();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hBAD0_BAD0; tick();
        chk("post_rst_req",   32'(imem_req), 32'd1);
        chk("post_rst_pc",    pc_out, 32'h0000_0100);
        chk("post_rst_instr", instr_out, 32'd0);

        // Sequential wrap at the top of the address space
        jump_to(32'hFFFF_FFFC);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("pc_wrap", imem_addr, 32'h0000_0000);

        // Misaligned JAL target from 0x40
        jump_to(32'h0000_0040);
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_flag", 32'(misalign_exc), 32'd1);
        chk("misalign_pc",   pc_out, 32'h0000_0040);
        halt_reqs = 0;
        for (int i = 0; i < 8; i++) begin
            imem_valid = 1'b1; instr_ack = 1'b1; tick();
            if (imem_req || instr_valid) halt_reqs++;
        end
        chk("halt_quiet", 32'(halt_reqs), 32'd0);
`else
        halt_reqs = 0;
        chk("misalign_forced", imem_addr, 32'h0000_0044);
        chk("misalign_halt_unused", 32'(halt_reqs), 32'd0);
`endif

        // Randomized traffic
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0) || (m_phase == 4 && $urandom_range(0, 3) == 0);
            imem_valid = 1'($urandom);
            imem_rdata = $urandom;
            instr_ack  = 1'($urandom);
            is_branch  = 1'($urandom); branchtrue = 1'($urandom);
            is_jal     = ($urandom_range(0, 3) == 0); is_jalr = ($urandom_range(0, 3) == 0);
            imm        = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255)) - 32'd128
                                                     : {32'($urandom_range(0, 255)) - 32'd128} << 2;
            rs1        = ($urandom_range(0, 7) == 0) ? $urandom : {$urandom} & 32'hFFFF_FFFC;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the branch comparator; also consumes that comparator's branchtrue result.
- Holds the PC and fetches one instruction at a time from instruction memory over a req/valid handshake.
- Presents the instruction to decode/execute until the core acknowledges it, then selects the next PC: pc+4, branch, JAL or JALR.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- branchtrue  in  1  branch condition from the branch comparator for the held instruction.
- is_branch  in  1  held instruction is a conditional branch.
- is_jal  in  1  held instruction is JAL.
- is_jalr  in  1  held instruction is JALR.
- imm  in  32  sign-extended immediate of the held instruction.
- rs1  in  32  rs1 register value (JALR base).
- instr_ack  in  1  core has finished executing the held instruction.
- imem_req  out  1  fetch request, one-cycle pulse.
- imem_addr  out  32  fetch address (the current PC).
- imem_rdata  in  32  fetched instruction word.
- imem_valid  in  1  imem_rdata is valid.
- instr_out  out  32  held instruction.
- instr_valid  out  1  instr_out is valid.
- pc_out  out  32  PC of the held instruction.
- pc_plus4  out  32  pc_out+4, used for the JAL/JALR link value.
- misalign_exc  out  1  sticky misaligned-target flag; exists only when the optional feature is compiled in.

Behaviour:
- State machine:
  - BOOT: go to FETCH.
  - FETCH: imem_req=1; go to WAIT.
  - WAIT: on imem_valid, capture imem_rdata into instr_out and go to HOLD; otherwise stay in WAIT.
  - HOLD: instr_valid=1; on instr_ack, load the next PC and go to FETCH.
- Reset: asynchronous. Forces state=BOOT, pc_out=RESET_PC, instr_out=0, instr_valid=0, imem_req=0, misalign_exc=0. Reset mid-fetch abandons the outstanding request; a late imem_valid arriving in BOOT or FETCH is ignored.
- imem_req and instr_valid are decoded from registered state only, with no combinational path from inputs. imem_addr = pc_out at all times.
- imem_valid is sampled only in WAIT. instr_ack is sampled only in HOLD. Both are ignored in all other states.
- Latency: the first imem_req occurs in the 2nd cycle after reset release. With a 1-cycle memory and an immediate ack, each instruction takes 3 cycles (FETCH, WAIT, HOLD).
- instr_ack may be asserted in the first HOLD cycle.
- Next-PC priority, evaluated in the HOLD cycle where instr_ack=1:
  - is_jalr: (rs1+imm) & ~32'h1.
  - else is_jal, or (is_branch & branchtrue): pc_out+imm.
  - else: pc_out+4.
- All adds are 32-bit modulo 2^32; 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- pc_plus4 is combinational from pc_out.
- Control inputs (is_*, branchtrue, imm, rs1) may change freely outside the ack cycle.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: if the selected next-PC has bits[1:0] != 0, the PC is not updated, misalign_exc is set (sticky until reset), and the FSM enters HALT. HALT issues no further requests and keeps instr_valid=0.
- Undefined: the misalign_exc port is absent, the next-PC bits[1:0] are forced to 0, and there is no HALT state.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum (BOOT, FETCH, WAIT, HOLD, HALT);
  - localparam PC_INC = 32'd4;
  - default RESET_PC constant.
- One combinational sub-module, next_pc_calc (inputs: pc, imm, rs1, control bits; output: target and misaligned flag), instantiated once.

Test Plan:
- Reset with RESET_PC=0x100, 1-cycle memory, ack every HOLD:
  - imem_addr sequence is 0x100, 0x104, 0x108;
  - instr_valid pulses once every 3 cycles;
  - imem_req=0 during reset and during BOOT.
- Branch at pc=0x20 with is_branch=1 and imm=-8:
  - branchtrue=1 → next fetch address 0x18;
  - branchtrue=0 → next fetch address 0x24.
- JALR with rs1=0x1001, imm=0x10 → fetch 0x1010. If is_jal=1 is also asserted, the target is still 0x1010 (JALR priority).
- Memory stalls 4 cycles in WAIT, then ack is held off 3 cycles in HOLD:
  - instr_out remains stable;
  - no new imem_req is issued;
  - acks and valids arriving outside their sampling states are ignored.
- Reset asserted in WAIT with imem_valid arriving 1 cycle after release:
  - the stale word is dropped;
  - pc_out=RESET_PC;
  - a fresh request is issued.
- pc=0xFFFF_FFFC with a sequential ack → next fetch address 0x0.
- Misaligned target, with the macro defined: jal at pc=0x40 with imm=0x6 → misalign_exc=1, PC stays 0x40, no further requests.
- Same jal, with the macro undefined: fetch address 0x44 (target 0x46 with bits[1:0] forced to 0).
